hc595_scan_ctrl: RTL and testbench

//  Scan controller for the 8-digit 7-segment display behind the 74HC595 chain.

---
 rtl/hc595_scan_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_hc595_scan_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/hc595_scan_ctrl.sv
// ---------------------------------------------------------------------------------------------
// hc595_scan_ctrl
//
// Scan controller for an 8-digit 7-segment display driven through a chain of 74HC595 shift
// registers. The 32-bit display value arrives as four bytes and is treated as 8 hex nibbles.
// On every refresh tick one digit is sent as a 16-bit serial frame {seg[7:0], sel[7:0]}
// (MSB first) on clk/dat and then latched into the 595 outputs with a pulse on str. The whole
// 32-bit value is snapshotted when digit 0 is loaded, so a single scan never mixes old and new
// data.
//
// Parameters:
//   CLK_DIV      sys_clk cycles per half-period of clk and per str pulse (>= 1)
//   REFRESH_DIV  sys_clk cycles between digit-frame start ticks (>= 34*CLK_DIV)
//
// Ports:
//   sys_clk    system clock
//   sys_rst_n  asynchronous active-low reset
//   en         1 = scanning enabled; a frame already running always completes
//   data0..3   display value bytes, data0[3:0] is digit 0 (rightmost), data3[7:4] is digit 7
//   clk        595 shift clock, the 595 samples dat on its rising edge
//   dat        595 serial data, held stable across each clk high phase
//   str        595 storage-register latch strobe, active-high
//   busy       1 while a frame is in progress
//   digit_idx  digit currently being sent, or the next one to send when idle
//
// Optional feature (compile-time macro HC595_BLANK_LEADING_ZERO_EN):
//   When defined, digits 1..7 are blanked (seg = 8'hFF) whenever that nibble and every more
//   significant nibble of the snapshot are zero. Digit 0 is never blanked.
// ---------------------------------------------------------------------------------------------
module hc595_scan_ctrl #(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       en,
  input  logic [7:0] data0,
  input  logic [7:0] data1,
  input  logic [7:0] data2,
  input  logic [7:0] data3,
  output logic       clk,
  output logic       dat,
  output logic       str,
  output logic       busy,
  output logic [2:0] digit_idx
);

  localparam int unsigned RefW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [RefW-1:0] RefLast = RefW'(REFRESH_DIV - 1);
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StShiftLo,
    StShiftHi,
    StLatch
  } state_e;

  // Active-low segment pattern {dp,g,f,e,d,c,b,a}; dp is always off.
  function automatic logic [7:0] hex_seg(input logic [3:0] nib);
    logic [7:0] seg;
    case (nib)
      4'h0:    seg = 8'hC0;
      4'h1:    seg = 8'hF9;
      4'h2:    seg = 8'hA4;
      4'h3:    seg = 8'hB0;
      4'h4:    seg = 8'h99;
      4'h5:    seg = 8'h92;
      4'h6:    seg = 8'h82;
      4'h7:    seg = 8'hF8;
      4'h8:    seg = 8'h80;
      4'h9:    seg = 8'h90;
      4'hA:    seg = 8'h88;
      4'hB:    seg = 8'h83;
      4'hC:    seg = 8'hC6;
      4'hD:    seg = 8'hA1;
      4'hE:    seg = 8'h86;
      default: seg = 8'h8E;
    endcase
    return seg;
  endfunction

  // Segment pattern for digit k of a snapshot, including optional leading-zero blanking.
  function automatic logic [7:0] digit_seg(input logic [31:0] snap, input logic [2:0] k);
    logic [7:0] seg;
    seg = hex_seg(snap[{k, 2'b00} +: 4]);
`ifdef HC595_BLANK_LEADING_ZERO_EN
    // Shifting out the lower digits leaves nibbles k..7; all zero means a leading zero.
    if ((k != 3'd0) && ((snap >> {k, 2'b00}) == 32'd0)) begin
      seg = 8'hFF;
    end
`endif
    return seg;
  endfunction

  state_e          state_q, state_d;
  logic [RefW-1:0] ref_cnt_q, ref_cnt_d;
  logic            pending_q, pending_d;
  logic [31:0]     snap_q, snap_d;
  logic [15:0]     word_q, word_d;
  logic [3:0]      bit_q, bit_d;
  logic [DivW-1:0] div_q, div_d;
  logic            dat_q, dat_d;
  logic [2:0]      digit_q, digit_d;

  logic            tick;
  logic            div_last;
  logic [31:0]     snap_eff;
  logic [15:0]     word_new;

  // Free-running refresh counter; the terminal count is the frame-start tick.
  always_comb begin
    tick      = (ref_cnt_q == RefLast);
    ref_cnt_d = tick ? '0 : ref_cnt_q + 1'b1;
  end

  // Digit 0 takes a fresh snapshot; the word for it must be built from the live inputs in the
  // same LOAD cycle, so the effective snapshot bypasses the register in that case.
  always_comb begin
    snap_eff = (digit_q == 3'd0) ? {data3, data2, data1, data0} : snap_q;
    word_new = {digit_seg(snap_eff, digit_q), 8'(8'd1 << digit_q)};
    div_last = (div_q == DivLast);
  end

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q | tick;
    snap_d    = snap_q;
    word_d    = word_q;
    bit_d     = bit_q;
    div_d     = '0;
    dat_d     = dat_q;
    digit_d   = digit_q;

    // Phase counter runs only in the timed states and restarts on every state change.
    if ((state_q == StShiftLo) || (state_q == StShiftHi) || (state_q == StLatch)) begin
      div_d = div_last ? '0 : div_q + 1'b1;
    end

    case (state_q)
      StIdle: begin
        if ((tick || pending_q) && en) begin
          state_d   = StLoad;
          pending_d = 1'b0;
        end
      end
      StLoad: begin
        if (digit_q == 3'd0) begin
          snap_d = snap_eff;
        end
        word_d  = word_new;
        bit_d   = 4'd15;
        dat_d   = word_new[15];
        state_d = StShiftLo;
      end
      StShiftLo: begin
        if (div_last) begin
          state_d = StShiftHi;
        end
      end
      StShiftHi: begin
        if (div_last) begin
          if (bit_q == 4'd0) begin
            state_d = StLatch;
          end else begin
            bit_d   = bit_q - 1'b1;
            dat_d   = word_q[bit_q - 1'b1];
            state_d = StShiftLo;
          end
        end
      end
      StLatch: begin
        if (div_last) begin
          digit_d = digit_q + 1'b1;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= StIdle;
      ref_cnt_q <= '0;
      pending_q <= 1'b0;
      snap_q    <= '0;
      word_q    <= '0;
      bit_q     <= '0;
      div_q     <= '0;
      dat_q     <= 1'b0;
      digit_q   <= '0;
    end else begin
      state_q   <= state_d;
      ref_cnt_q <= ref_cnt_d;
      pending_q <= pending_d;
      snap_q    <= snap_d;
      word_q    <= word_d;
      bit_q     <= bit_d;
      div_q     <= div_d;
      dat_q     <= dat_d;
      digit_q   <= digit_d;
    end
  end

  // Control outputs decode the registered state, so reset forces them low immediately.
  always_comb begin
    clk       = (state_q == StShiftHi);
    str       = (state_q == StLatch);
    busy      = (state_q != StIdle);
    dat       = dat_q;
    digit_idx = digit_q;
  end

endmodule

// File: tb/tb_hc595_scan_ctrl.sv
// Bench for hc595_scan_ctrl: a frame monitor reassembles each serial word from clk/dat and
// compares it, plus frame timing, against expected frames queued by the stimulus process.
module tb_hc595_scan_ctrl;

  localparam int unsigned ClkDiv     = 2;
  localparam int unsigned RefreshDiv = 80;
  localparam int          FrameLen   = 1 + 33 * ClkDiv;

`ifdef HC595_BLANK_LEADING_ZERO_EN
  localparam logic [7:0] LeadSeg = 8'hFF;
`else
  localparam logic [7:0] LeadSeg = 8'hC0;
`endif

  typedef struct {
    logic [31:0] data;
    logic [2:0]  digit;
    logic [15:0] word;
  } vec_t;

  typedef struct {
    logic [2:0]  digit;
    logic [15:0] word;
  } frame_t;

  logic       sys_clk;
  logic       sys_rst_n;
  logic       en;
  logic [7:0] data0, data1, data2, data3;
  logic       clk, dat, str, busy;
  logic [2:0] digit_idx;

  int errors = 0;
  int checks = 0;
  frame_t exp_q[$];

  hc595_scan_ctrl #(
    .CLK_DIV    (ClkDiv),
    .REFRESH_DIV(RefreshDiv)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .en       (en),
    .data0    (data0),
    .data1    (data1),
    .data2    (data2),
    .data3    (data3),
    .clk      (clk),
    .dat      (dat),
    .str      (str),
    .busy     (busy),
    .digit_idx(digit_idx)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic set_data(input logic [31:0] v);
    {data3, data2, data1, data0} = v;
  endtask

  // Wait for the monitor to consume every queued frame, bounded by a cycle budget.
  task automatic drain(input string name, input int budget);
    for (int c = 0; c < budget && exp_q.size() > 0; c++) @(posedge sys_clk);
    if (exp_q.size() > 0) begin
      chk({name, "_timeout"}, exp_q.size(), 0);
      exp_q.delete();
    end
  endtask

  // Frame monitor, sampling on the falling sys_clk edge.
  initial begin : monitor
    logic        pclk, pstr, pbusy, sfol;
    logic [15:0] sh;
    logic [2:0]  dig;
    int          rises, blen, slen;
    frame_t      e;
    pclk = 0; pstr = 0; pbusy = 0; sfol = 0; sh = '0; dig = '0;
    rises = 0; blen = 0; slen = 0;
    forever begin
      @(negedge sys_clk);
      if (!sys_rst_n) begin
        pclk = 0; pstr = 0; pbusy = 0;
      end else begin
        if (busy && !pbusy) begin
          rises = 0; blen = 0; slen = 0; sh = '0; sfol = 0; dig = digit_idx;
        end
        if (busy) blen++;
        if (clk && !pclk) begin
          sh = {sh[14:0], dat};
          rises++;
        end
        if (str) slen++;
        if (str && !pstr) sfol = pclk;
        if (!busy && pbusy && exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("frame_word", {16'd0, sh}, {16'd0, e.word});
          chk("frame_digit", {29'd0, dig}, {29'd0, e.digit});
          chk("frame_clk_rises", rises, 16);
          chk("frame_len", blen, FrameLen);
          chk("str_len", slen, ClkDiv);
          chk("str_after_clk_hi", {31'd0, sfol}, 32'd1);
        end
        pclk = clk; pstr = str; pbusy = busy;
      end
    end
  end

  vec_t scan_tbl[17];
  vec_t zero_tbl[8];

  initial begin : stimulus
    int   rises;
    logic pclk, hit, seen;
    frame_t f;

    // Full scan, wrap to digit 0, then a data change mid-scan that must wait for digit 0.
    scan_tbl[0]  = '{32'h12345678, 3'd0, 16'h8001};
    scan_tbl[1]  = '{32'h12345678, 3'd1, 16'hF802};
    scan_tbl[2]  = '{32'h12345678, 3'd2, 16'h8204};
    scan_tbl[3]  = '{32'h12345678, 3'd3, 16'h9208};
    scan_tbl[4]  = '{32'h12345678, 3'd4, 16'h9910};
    scan_tbl[5]  = '{32'h12345678, 3'd5, 16'hB020};
    scan_tbl[6]  = '{32'h12345678, 3'd6, 16'hA440};
    scan_tbl[7]  = '{32'h12345678, 3'd7, 16'hF980};
    scan_tbl[8]  = '{32'h12345678, 3'd0, 16'h8001};
    scan_tbl[9]  = '{32'h12345678, 3'd1, 16'hF802};
    scan_tbl[10] = '{32'h12345678, 3'd2, 16'h8204};
    scan_tbl[11] = '{32'h12345678, 3'd3, 16'h9208};
    scan_tbl[12] = '{32'hFFFFFFFF, 3'd4, 16'h9910};
    scan_tbl[13] = '{32'hFFFFFFFF, 3'd5, 16'hB020};
    scan_tbl[14] = '{32'hFFFFFFFF, 3'd6, 16'hA440};
    scan_tbl[15] = '{32'hFFFFFFFF, 3'd7, 16'hF980};
    scan_tbl[16] = '{32'hFFFFFFFF, 3'd0, 16'h8E01};

    zero_tbl[0] = '{32'h000000A0, 3'd0, 16'hC001};
    zero_tbl[1] = '{32'h000000A0, 3'd1, 16'h8802};
    for (int k = 2; k < 8; k++) zero_tbl[k] = '{32'h000000A0, 3'(k), {LeadSeg, 8'(8'd1 << k)}};

    // Reset with the clock running and scanning enabled.
    sys_rst_n = 1'b0;
    en        = 1'b1;
    set_data(32'h12345678);
    repeat (3) @(posedge sys_clk);
    #1;
    chk("rst_clk", {31'd0, clk}, 32'd0);
    chk("rst_dat", {31'd0, dat}, 32'd0);
    chk("rst_str", {31'd0, str}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_digit_idx", {29'd0, digit_idx}, 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    // Each record: drive its data right after the previous frame, then expect one frame.
    for (int i = 0; i < 17; i++) begin
      set_data(scan_tbl[i].data);
      f.digit = scan_tbl[i].digit;
      f.word  = scan_tbl[i].word;
      exp_q.push_back(f);
      drain("scan", 3 * RefreshDiv);
    end

    // Asynchronous reset during the clk-high phase of bit 7 of the next frame.
    rises = 0; pclk = 0; hit = 0;
    for (int c = 0; c < 4 * RefreshDiv && !hit; c++) begin
      @(posedge sys_clk);
      #1;
      if (!busy) rises = 0;
      else if (clk && !pclk) rises++;
      pclk = clk;
      if (rises == 9) hit = 1'b1;
    end
    chk("mid_frame_reached", {31'd0, hit}, 32'd1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    chk("async_rst_clk", {31'd0, clk}, 32'd0);
    chk("async_rst_dat", {31'd0, dat}, 32'd0);
    chk("async_rst_str", {31'd0, str}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
    chk("async_rst_digit_idx", {29'd0, digit_idx}, 32'd0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    f.digit = 3'd0;
    f.word  = 16'h8E01;
    exp_q.push_back(f);
    drain("after_rst", 3 * RefreshDiv);

    // en=0: no new frame may start.
    en   = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 4 * RefreshDiv; c++) begin
      @(posedge sys_clk);
      #1;
      if (busy) seen = 1'b1;
    end
    chk("en0_no_frame", {31'd0, seen}, 32'd0);
    en = 1'b1;
    f.digit = 3'd1;
    f.word  = 16'h8E02;
    exp_q.push_back(f);
    drain("en_resume", 3 * RefreshDiv);

    // Leading-zero pattern from a fresh reset.
    sys_rst_n = 1'b0;
    set_data(32'h000000A0);
    repeat (2) @(posedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      f.digit = zero_tbl[i].digit;
      f.word  = zero_tbl[i].word;
      exp_q.push_back(f);
    end
    drain("lead_zero", 10 * RefreshDiv);

    repeat (5) @(posedge sys_clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
